// File: rtl/cpu_pkg.sv
// Shared definitions for the instruction fetch path: FSM state encoding
// and the default geometry of the fetch unit.
package cpu_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      FETCH = 2'b01,
      FULL  = 2'b10,
      FLUSH = 2'b11
   } fetch_state_t;

   localparam int DEF_ADDR_W   = 8;
   localparam int DEF_INSTR_W  = 32;
   localparam int DEF_RAM_SIZE = 4;
   localparam int DEF_QDEPTH   = 4;

endpackage

// File: rtl/fetch_fifo.sv
// Prefetch queue: circular buffer of DEPTH entries (any DEPTH >= 2, not
// only powers of two). Clear empties it and wins over push and pop.
// The head output reads as zero while the queue is empty.
module fetch_fifo #(
   parameter int WIDTH = 40,
   parameter int DEPTH = 4
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         push,
   input  logic                         pop,
   input  logic                         clear,
   input  logic [WIDTH-1:0]             din,
   output logic [WIDTH-1:0]             dout,
   output logic [$clog2(DEPTH+1)-1:0]   count
);

   localparam int CNT_W = $clog2(DEPTH+1);
   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] rd_ptr;
   logic [PTR_W-1:0] wr_ptr;
   logic             full;
   logic             do_push;
   logic             do_pop;

   // Pointer increment with explicit wrap so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] p);
      return (p == PTR_W'(DEPTH-1)) ? '0 : p + PTR_W'(1);
   endfunction

   assign full    = (count == CNT_W'(DEPTH));
   assign do_pop  = pop && !clear && (count != '0);
   assign do_push = push && !clear && (!full || do_pop);
   assign dout    = (count != '0) ? mem[rd_ptr] : '0;

   // Entry storage: data words carry no reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= din;
   end

   // Pointer and occupancy bookkeeping.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else if (clear) begin
         rd_ptr <= '0;
         wr_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= bump(wr_ptr);
         if (do_pop)  rd_ptr <= bump(rd_ptr);
         if (do_push && !do_pop)      count <= count + CNT_W'(1);
         else if (!do_push && do_pop) count <= count - CNT_W'(1);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: issues one outstanding read at a time, keeps a
// prefetch queue of {instruction, address}, and handles redirects. A
// redirect that lands while a read is in flight waits in FLUSH for that
// read to complete and throws its data away.
module fetch_unit
   import cpu_pkg::*;
#(
   parameter int ADDR_W   = DEF_ADDR_W,
   parameter int INSTR_W  = DEF_INSTR_W,
   parameter int RAM_SIZE = DEF_RAM_SIZE,
   parameter int QDEPTH   = DEF_QDEPTH
) (
   input  logic               clk,
   input  logic               reset,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   input  logic               mem_ack,
   input  logic [INSTR_W-1:0] mem_rdata,
   input  logic               jmp_valid,
   input  logic [ADDR_W-1:0]  jmp_addr,
   output logic               ir_valid,
   output logic [INSTR_W-1:0] ir,
   output logic [ADDR_W-1:0]  ir_pc,
   input  logic               ir_ready,
   output logic [ADDR_W-1:0]  pc,
   output logic [1:0]         state,
   output logic               fault
);

   localparam int CNT_W = $clog2(QDEPTH+1);
   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(RAM_SIZE-1);

   fetch_state_t               st;
   logic [CNT_W-1:0]           count;
   logic [CNT_W-1:0]           count_nx;
   logic                       push;
   logic                       pop;
   logic                       jmp_bad;
   logic [ADDR_W-1:0]          jmp_tgt;
   logic [ADDR_W-1:0]          pc_inc;
   logic [INSTR_W+ADDR_W-1:0]  head;

   assign state    = st;
   assign ir_valid = (count != '0) && (st != FLUSH);
   assign pop      = ir_valid && ir_ready;
   assign push     = ((st == FETCH) || (st == FULL)) && mem_req && mem_ack && !jmp_valid;
   assign jmp_bad  = (32'(jmp_addr) >= RAM_SIZE);
   assign jmp_tgt  = jmp_bad ? '0 : jmp_addr;
   assign pc_inc   = (pc == LAST_ADDR) ? '0 : pc + ADDR_W'(1);
   assign ir       = head[ADDR_W +: INSTR_W];
   assign ir_pc    = head[ADDR_W-1:0];

   // Queue occupancy after the coming edge, used for issue and FULL decisions.
   always_comb begin
      count_nx = count;
      if (jmp_valid)           count_nx = '0;
      else if (push && !pop)   count_nx = count + CNT_W'(1);
      else if (!push && pop)   count_nx = count - CNT_W'(1);
   end

   fetch_fifo #(
      .WIDTH (INSTR_W + ADDR_W),
      .DEPTH (QDEPTH)
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .push  (push),
      .pop   (pop),
      .clear (jmp_valid),
      .din   ({mem_rdata, mem_addr}),
      .dout  (head),
      .count (count)
   );

   // Fetch control FSM with registered request, address, pc and fault.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         st       <= IDLE;
         pc       <= '0;
         mem_req  <= 1'b0;
         mem_addr <= '0;
         fault    <= 1'b0;
      end else if (jmp_valid) begin
         pc <= jmp_tgt;
         if (jmp_bad) fault <= 1'b1;
         if (st == FLUSH) begin
            if (mem_ack) begin
               mem_req <= 1'b0;
               st      <= FETCH;
            end
         end else if (mem_req && !mem_ack) begin
            st <= FLUSH;
         end else begin
            mem_req <= 1'b0;
            st      <= FETCH;
         end
      end else begin
         case (st)
            IDLE: st <= FETCH;
            FETCH: begin
               if (mem_req) begin
                  if (mem_ack) begin
                     mem_req <= 1'b0;
                     pc      <= pc_inc;
                     if (count_nx == CNT_W'(QDEPTH)) st <= FULL;
                  end
               end else if (count_nx < CNT_W'(QDEPTH)) begin
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
               end else begin
                  st <= FULL;
               end
            end
            FULL: begin
               if (count_nx < CNT_W'(QDEPTH)) begin
                  st       <= FETCH;
                  mem_req  <= 1'b1;
                  mem_addr <= pc;
               end
            end
            FLUSH: begin
               if (mem_ack) begin
                  mem_req <= 1'b0;
                  st      <= FETCH;
               end
            end
            default: st <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: a delivery-order model (next address the
// consumer must see, sticky fault, request hold rule) checked every cycle,
// plus literal expectations for each scenario.
module tb_fetch_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        rb = 1'b1;
   logic        auto_ack = 1'b1;
   logic        man_ack = 1'b0;
   logic        ir_ready = 1'b0;
   logic        jmp_valid = 1'b0;
   logic [7:0]  jmp_addr = 8'd0;

   logic        mem_req, mem_ack, ir_valid, fault;
   logic [7:0]  mem_addr, ir_pc, pc;
   logic [31:0] mem_rdata, ir;
   logic [1:0]  state;

   logic        mem_req_b, ir_valid_b, fault_b;
   logic [2:0]  mem_addr_b, ir_pc_b, pc_b;
   logic [31:0] ir_b;
   logic [1:0]  state_b;
   logic        jv_b = 1'b0;
   logic [2:0]  ja_b = 3'd0;
   logic        rdy_b = 1'b1;

   int checks = 0;
   int errors = 0;

   function automatic logic [31:0] word(input int a);
      return 32'h11 * (a + 1);
   endfunction

   assign mem_ack   = auto_ack ? mem_req : man_ack;
   assign mem_rdata = word(int'(mem_addr));

   fetch_unit dut (
      .clk(clk), .reset(reset), .mem_req(mem_req), .mem_addr(mem_addr),
      .mem_ack(mem_ack), .mem_rdata(mem_rdata), .jmp_valid(jmp_valid),
      .jmp_addr(jmp_addr), .ir_valid(ir_valid), .ir(ir), .ir_pc(ir_pc),
      .ir_ready(ir_ready), .pc(pc), .state(state), .fault(fault)
   );

   fetch_unit #(.ADDR_W(3), .INSTR_W(32), .RAM_SIZE(5), .QDEPTH(4)) dut_b (
      .clk(clk), .reset(rb), .mem_req(mem_req_b), .mem_addr(mem_addr_b),
      .mem_ack(mem_req_b), .mem_rdata(word(int'(mem_addr_b))), .jmp_valid(jv_b),
      .jmp_addr(ja_b), .ir_valid(ir_valid_b), .ir(ir_b), .ir_pc(ir_pc_b),
      .ir_ready(rdy_b), .pc(pc_b), .state(state_b), .fault(fault_b)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      tick();
      reset = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_state"}, state, 2'b00);
      chk({tag, "_mem_req"}, mem_req, 1'b0);
      chk({tag, "_mem_addr"}, mem_addr, 8'd0);
      chk({tag, "_pc"}, pc, 8'd0);
      chk({tag, "_ir_valid"}, ir_valid, 1'b0);
      chk({tag, "_ir"}, ir, 32'd0);
      chk({tag, "_ir_pc"}, ir_pc, 8'd0);
      chk({tag, "_fault"}, fault, 1'b0);
      chk({tag, "_count"}, dut.count, 3'd0);
   endtask

   // Delivery-order model: next address owed to the consumer, sticky fault,
   // and the rule that a pending request holds until acknowledged.
   int          exp_pc = 0;
   logic        exp_fault = 1'b0;
   logic        pend = 1'b0;
   logic [7:0]  pend_addr = 8'd0;

   always @(negedge clk) begin
      if (reset) begin
         exp_pc    = 0;
         exp_fault = 1'b0;
         pend      = 1'b0;
      end else begin
         chk("m_fault", fault, exp_fault);
         if (ir_valid) begin
            chk("m_ir_pc", ir_pc, 8'(exp_pc));
            chk("m_ir", ir, word(exp_pc));
         end
         if (pend) begin
            chk("m_req_hold", mem_req, 1'b1);
            chk("m_addr_hold", mem_addr, pend_addr);
         end
         pend      = mem_req && !mem_ack;
         pend_addr = mem_addr;
         if (jmp_valid) begin
            if (int'(jmp_addr) >= 4) begin
               exp_pc    = 0;
               exp_fault = 1'b1;
            end else begin
               exp_pc = int'(jmp_addr);
            end
         end else if (ir_valid && ir_ready) begin
            exp_pc = (exp_pc + 1) % 4;
         end
      end
   end

   initial begin
      int pcs[$];
      logic [31:0] words[$];
      int exp_seq[6] = '{0, 1, 2, 3, 0, 1};
      int exp_seq_b[7] = '{0, 1, 2, 3, 4, 0, 1};
      int pops;

      // Reset values
      tick();
      chk_reset_vals("rst0");

      // Queue fills with no consumer, then one pop reopens fetching
      ir_ready = 1'b0;
      auto_ack = 1'b1;
      reset = 1'b0;
      for (int i = 0; i < 40 && state != 2'b10; i++) tick();
      chk("full_state", state, 2'b10);
      chk("full_count", dut.count, 3'd4);
      chk("full_req", mem_req, 1'b0);
      chk("full_head", ir_pc, 8'd0);
      tick();
      tick();
      chk("full_hold_state", state, 2'b10);
      chk("full_hold_req", mem_req, 1'b0);
      ir_ready = 1'b1;
      tick();
      ir_ready = 1'b0;
      chk("pop_state", state, 2'b01);
      chk("pop_req", mem_req, 1'b1);
      chk("pop_addr", mem_addr, 8'd0);
      chk("pop_count", dut.count, 3'd3);

      // Streaming with zero-wait memory
      ir_ready = 1'b1;
      do_reset();
      for (int i = 0; i < 60 && pcs.size() < 6; i++) begin
         @(negedge clk);
         if (ir_valid) begin
            pcs.push_back(int'(ir_pc));
            words.push_back(ir);
         end
      end
      chk("stream_len", pcs.size(), 6);
      for (int i = 0; i < 6; i++) begin
         chk("stream_pc", (i < pcs.size()) ? pcs[i] : -1, exp_seq[i]);
         chk("stream_ir", (i < words.size()) ? words[i] : 32'hffffffff, word(exp_seq[i]));
      end
      pops = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (ir_valid) pops++;
      end
      chk("throughput", pops, 10);
      chk("stream_fault", fault, 1'b0);
      tick();

      // Redirect while a slow read to address 1 is in flight
      auto_ack = 1'b0;
      man_ack = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && !(mem_req && mem_addr == 8'd0); i++) tick();
      chk("fl_req0", {mem_req, mem_addr}, {1'b1, 8'd0});
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      for (int i = 0; i < 20 && !(mem_req && mem_addr == 8'd1); i++) tick();
      chk("fl_req1", {mem_req, mem_addr}, {1'b1, 8'd1});
      jmp_valid = 1'b1;
      jmp_addr = 8'd2;
      tick();
      jmp_valid = 1'b0;
      chk("fl_state", state, 2'b11);
      chk("fl_req", mem_req, 1'b1);
      chk("fl_addr", mem_addr, 8'd1);
      chk("fl_pc", pc, 8'd2);
      chk("fl_irv", ir_valid, 1'b0);
      tick();
      chk("fl_state2", state, 2'b11);
      tick();
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("fl_done_state", state, 2'b01);
      chk("fl_done_count", dut.count, 3'd0);
      chk("fl_done_pc", pc, 8'd2);
      auto_ack = 1'b1;
      for (int i = 0; i < 20 && !ir_valid; i++) tick();
      chk("fl_first_pc", ir_pc, 8'd2);
      chk("fl_first_ir", ir, 32'h33);

      // Out-of-range redirect
      ir_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 40 && state != 2'b10; i++) tick();
      chk("bad_pre_state", state, 2'b10);
      jmp_valid = 1'b1;
      jmp_addr = 8'd7;
      tick();
      jmp_valid = 1'b0;
      chk("bad_pc", pc, 8'd0);
      chk("bad_fault", fault, 1'b1);
      chk("bad_state", state, 2'b01);
      chk("bad_irv", ir_valid, 1'b0);
      ir_ready = 1'b1;
      for (int i = 0; i < 20 && !ir_valid; i++) tick();
      chk("bad_next_pc", ir_pc, 8'd0);
      for (int i = 0; i < 20 && !(mem_req && mem_ack); i++) tick();
      jmp_valid = 1'b1;
      jmp_addr = 8'd3;
      tick();
      jmp_valid = 1'b0;
      for (int i = 0; i < 20 && !ir_valid; i++) tick();
      chk("jmp_push_pc", ir_pc, 8'd3);
      for (int i = 0; i < 10; i++) tick();
      chk("bad_fault_sticky", fault, 1'b1);

      // Reset in the middle of a request, late ack afterwards
      auto_ack = 1'b0;
      man_ack = 1'b0;
      ir_ready = 1'b0;
      do_reset();
      for (int i = 0; i < 20 && !(mem_req && mem_addr == 8'd0); i++) tick();
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      for (int i = 0; i < 20 && !(mem_req && mem_addr == 8'd1); i++) tick();
      chk("mid_pre_count", dut.count, 3'd1);
      reset = 1'b1;
      #1;
      chk_reset_vals("mid");
      tick();
      reset = 1'b0;
      man_ack = 1'b1;
      tick();
      man_ack = 1'b0;
      chk("late_count", dut.count, 3'd0);
      chk("late_irv", ir_valid, 1'b0);
      chk("late_state", state, 2'b01);
      tick();
      chk("late_count2", dut.count, 3'd0);
      chk("late_irv2", ir_valid, 1'b0);

      // Non-power-of-two program size wraps 4 -> 0
      pcs.delete();
      words.delete();
      rb = 1'b0;
      for (int i = 0; i < 80 && pcs.size() < 7; i++) begin
         @(negedge clk);
         if (ir_valid_b) begin
            pcs.push_back(int'(ir_pc_b));
            words.push_back(ir_b);
         end
      end
      chk("wrap_len", pcs.size(), 7);
      for (int i = 0; i < 7; i++) begin
         chk("wrap_pc", (i < pcs.size()) ? pcs[i] : -1, exp_seq_b[i]);
         chk("wrap_ir", (i < words.size()) ? words[i] : 32'hffffffff, word(exp_seq_b[i]));
      end
      chk("wrap_fault", fault_b, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_W, default 8, is the width of every program address.
REQ-002 Parameter INSTR_W, default 32, is the instruction word width.
REQ-003 Parameter RAM_SIZE, default 4, is the number of valid program words; any value 1..2^ADDR_W is legal, including non-powers of two.
REQ-004 Parameter QDEPTH, default 4, is the prefetch queue depth; minimum 2.
REQ-005 Ports SHALL be as follows; one clock; reset is asynchronous and active-high:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- mem_req  out  1  memory read request
- mem_addr  out  ADDR_W  request address
- mem_ack  in  1  read data valid; completes the request
- mem_rdata  in  INSTR_W  read data
- jmp_valid  in  1  redirect strobe
- jmp_addr  in  ADDR_W  redirect target
- ir_valid  out  1  queue head valid
- ir  out  INSTR_W  queue head instruction
- ir_pc  out  ADDR_W  address of ir
- ir_ready  in  1  consumer pops head
- pc  out  ADDR_W  next fetch address
- state  out  2  FSM state
- fault  out  1  sticky bad-jump flag

Function
REQ-006 FSM states SHALL be IDLE=00, FETCH=01, FULL=10, FLUSH=11.
REQ-007 IDLE SHALL go to FETCH on the first clk edge after reset deasserts.
REQ-008 In FETCH, mem_req SHALL assert when (queue count + outstanding) < QDEPTH; one request at most outstanding.
REQ-009 Once mem_req asserts, mem_req and mem_addr SHALL hold stable until the cycle in which mem_ack is high.
REQ-010 On mem_ack in FETCH/FULL, {mem_rdata, mem_addr} SHALL be pushed into the queue on that edge, and pc SHALL advance by 1, wrapping RAM_SIZE-1 -> 0.
REQ-011 A new request MAY issue in the cycle after ack; sustained throughput SHALL be one word per two cycles with zero-wait memory.
REQ-012 FETCH SHALL go to FULL when count reaches QDEPTH with no request outstanding; FULL SHALL return to FETCH in the cycle after a pop.
REQ-013 ir_valid SHALL equal (count != 0) and state != FLUSH; ir/ir_pc SHALL show the head entry; pop occurs when ir_valid and ir_ready are both high.
REQ-014 Simultaneous push and pop SHALL leave count unchanged and keep FIFO order.
REQ-015 jmp_valid SHALL empty the queue on that edge, set pc to jmp_addr, and override any same-cycle push; a same-cycle pop counts as consumed.
REQ-016 If jmp_addr >= RAM_SIZE, pc SHALL be set to 0 and fault SHALL set and stay set until reset.
REQ-017 A jump with no request outstanding SHALL go directly to FETCH; with a request outstanding, it SHALL go to FLUSH.
REQ-018 In FLUSH, mem_req SHALL stay high at the old address until mem_ack; that data SHALL be discarded, then the FSM SHALL go to FETCH.
REQ-019 A jump while in FLUSH SHALL update pc only; the FSM SHALL stay in FLUSH.

Reset
REQ-020 Reset SHALL force, asynchronously: pc=0, mem_req=0, mem_addr=0, count=0, ir_valid=0, ir=0, ir_pc=0, state=IDLE, fault=0.
REQ-021 Reset asserted mid-request SHALL drop the request; a late mem_ack after reset SHALL be ignored until the FSM reaches FETCH.

Structure
REQ-022 State encodings and default parameter values SHALL live in a shared package, cpu_pkg.
REQ-023 The queue SHALL be a sub-module, fetch_fifo, parametrised by width and depth with push, pop, and clear inputs and a count output.

Verification
REQ-024 RAM_SIZE=4, zero-wait memory with words 0x11..0x44, ir_ready=1: ir_pc sequence SHALL be 0,1,2,3,0,1; fault SHALL stay 0.
REQ-025 ir_ready=0, QDEPTH=4: state SHALL be FULL with count=4 and mem_req=0; one pop SHALL make mem_req rise the following cycle.
REQ-026 jmp_valid with jmp_addr=2 while a request is outstanding to address 1 and ack is delayed 3 cycles: state SHALL be FLUSH, the address-1 data SHALL never appear, and the first ir_pc SHALL be 2.
REQ-027 jmp_addr=7 with RAM_SIZE=4: pc SHALL be 0, fault SHALL be 1 and stay 1, and the next ir_pc SHALL be 0.
REQ-028 Reset pulsed mid-request with mem_ack arriving 1 cycle later: all outputs SHALL be at reset values and the ack SHALL not enqueue.
REQ-029 RAM_SIZE=5, ADDR_W=3: ir_pc SHALL wrap 4 -> 0.
